alu3_cmd_seq: RTL and testbench

ALU3_CMD_SEQ -- requirements
Module: alu3_cmd_seq

---
 rtl/alu3_pkg.sv | 22 ++
 rtl/alu3_core.sv | 49 ++++
 rtl/alu3_cmd_seq.sv | 151 +++++++++++++++
 tb/tb_alu3_cmd_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu3_pkg.sv
// Shared types for the alu3 command sequencer.
//   op_e    : command opcode (ADD, SUB, AND, SHR)
//   state_e : sequencer FSM state (IDLE, EXEC, DONE)
package alu3_pkg;

   localparam int unsigned OP_W    = 2;
   localparam int unsigned STATE_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_AND = 2'd2,
      OP_SHR = 2'd3
   } op_e;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : alu3_pkg

// File: rtl/alu3_core.sv
// Single-cycle combinational ALU datapath: ADD, SUB, AND and a one-bit
// logical right shift.
//   op     : opcode
//   a, b   : operands (b unused by SHR, which always shifts by one)
//   res_c  : result, DW bits
//   flag_c : carry (ADD), borrow (SUB), 0 (AND), bit shifted out (SHR)
module alu3_core
   import alu3_pkg::*;
#(
   parameter int unsigned DW = 3
) (
   input  op_e           op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] res_c,
   output logic          flag_c
);

   logic [DW:0] sum_c;
   logic [DW:0] diff_c;

   // One extra bit gives carry for ADD and borrow (a < b) for SUB
   assign sum_c  = {1'b0, a} + {1'b0, b};
   assign diff_c = {1'b0, a} - {1'b0, b};

   always_comb begin
      res_c  = '0;
      flag_c = 1'b0;
      case (op)
         OP_ADD: begin
            res_c  = sum_c[DW-1:0];
            flag_c = sum_c[DW];
         end
         OP_SUB: begin
            res_c  = diff_c[DW-1:0];
            flag_c = diff_c[DW];
         end
         OP_AND: begin
            res_c  = a & b;
            flag_c = 1'b0;
         end
         OP_SHR: begin
            res_c  = {1'b0, a[DW-1:1]};
            flag_c = a[0];
         end
      endcase
   end

endmodule : alu3_core

// File: rtl/alu3_cmd_seq.sv
// Command-driven ALU sequencer. Accepts one command in IDLE, produces the
// result one cycle later (ADD/SUB/AND, SHR by 0) or after 1+B cycles for
// SHR (one bit per cycle in EXEC), then holds it in DONE until consumed.
// Optional macro ALU3_CMD_SEQ_ZFLAG_EN adds the res_zero output.
//   clk, rst_n           : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_op, cmd_a, cmd_b : opcode, operand A, operand B / shift count
//   res_valid/res_ready  : result handshake
//   res_data, res_flag   : result and carry/borrow/shift-out flag
//   res_zero             : (macro only) result is zero while res_valid
module alu3_cmd_seq
   import alu3_pkg::*;
#(
   parameter int unsigned DW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [DW-1:0] cmd_a,
   input  logic [DW-1:0] cmd_b,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data,
   output logic          res_flag
`ifdef ALU3_CMD_SEQ_ZFLAG_EN
   ,
   output logic          res_zero
`endif
);

   state_e        state_q, state_d;
   logic [DW-1:0] data_q, data_d;
   logic          flag_q, flag_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          res_valid_q, res_valid_d;

   op_e           core_op;
   logic [DW-1:0] core_a;
   logic [DW-1:0] core_res;
   logic          core_flag;

   // In EXEC the core is reused as a one-bit shifter on the held result
   always_comb begin
      core_op = op_e'(cmd_op);
      core_a  = cmd_a;
      if (state_q == ST_EXEC) begin
         core_op = OP_SHR;
         core_a  = data_q;
      end
   end

   alu3_core #(
      .DW (DW)
   ) u_core (
      .op     (core_op),
      .a      (core_a),
      .b      (cmd_b),
      .res_c  (core_res),
      .flag_c (core_flag)
   );

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      flag_d  = flag_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (op_e'(cmd_op) == OP_SHR) begin
                  // Load A unshifted; EXEC performs all B shifts
                  data_d = cmd_a;
                  flag_d = 1'b0;
                  cnt_d  = cmd_b;
                  state_d = (cmd_b == '0) ? ST_DONE : ST_EXEC;
               end else begin
                  data_d  = core_res;
                  flag_d  = core_flag;
                  state_d = ST_DONE;
               end
            end
         end
         ST_EXEC: begin
            data_d = core_res;
            flag_d = core_flag;
            cnt_d  = cnt_q - DW'(1);
            if (cnt_q == DW'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      res_valid_d = (state_d == ST_DONE);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         data_q      <= '0;
         flag_q      <= 1'b0;
         cnt_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         flag_q      <= flag_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
      end
   end

   // Ready is gated by rst_n so it is low throughout reset and high as
   // soon as reset releases
   assign cmd_ready = rst_n && (state_q == ST_IDLE);
   assign res_valid = res_valid_q;
   assign res_data  = data_q;
   assign res_flag  = flag_q;

`ifdef ALU3_CMD_SEQ_ZFLAG_EN
   logic zero_q, zero_d;

   // Zero indication registered alongside the result it describes
   always_comb begin
      zero_d = (state_d == ST_DONE) && (data_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
      end else begin
         zero_q <= zero_d;
      end
   end

   assign res_zero = zero_q;
`endif

endmodule : alu3_cmd_seq

// File: tb/tb_alu3_cmd_seq.sv
// Self-checking bench for alu3_cmd_seq (DW=3): directed vectors, hold in
// DONE, reset during EXEC, randomized and back-to-back commands, checked
// against an arithmetic reference model.
module tb_alu3_cmd_seq;

   localparam int unsigned DW = 3;
   localparam int          M  = 1 << DW;

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [DW-1:0] cmd_a;
   logic [DW-1:0] cmd_b;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;
   logic          res_flag;
`ifdef ALU3_CMD_SEQ_ZFLAG_EN
   logic          res_zero;
`endif

   int n_cmp;
   int n_err;

   alu3_cmd_seq #(
      .DW (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_flag  (res_flag)
`ifdef ALU3_CMD_SEQ_ZFLAG_EN
      ,
      .res_zero  (res_zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one command from IDLE (called at a negedge), check latency and
   // result, hold it for 'hold' cycles, then consume it.
   task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input int hold);
      int            ai, bi, s, exp_lat, k;
      logic [DW-1:0] exp_d, d0;
      logic          exp_f, f0, got;
      ai = int'(a);
      bi = int'(b);
      exp_lat = 1;
      exp_f   = 1'b0;
      case (op)
         2'd0: begin
            s = ai + bi;
            exp_d = DW'(s % M);
            exp_f = (s >= M);
         end
         2'd1: begin
            exp_d = DW'((ai - bi + M) % M);
            exp_f = (ai < bi);
         end
         2'd2: begin
            exp_d = DW'(ai & bi);
         end
         default: begin
            exp_d = DW'(ai >> bi);
            exp_f = (bi == 0) ? 1'b0 : 1'((ai >> (bi - 1)) & 1);
            exp_lat = 1 + bi;
         end
      endcase

      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      @(posedge clk);
      #1;
      // Scramble inputs after acceptance; they must not matter
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_a     = DW'($urandom);
      cmd_b     = DW'($urandom);

      k   = 0;
      got = 1'b0;
      while (k < 40 && !got) begin
         @(negedge clk);
         k++;
         if (res_valid === 1'b1) got = 1'b1;
      end
      n_cmp++;
      if (!got || k != exp_lat) begin
         n_err++;
         $display("FAIL latency op=%0d a=%0d b=%0d: got %0d cycles (seen=%b) want %0d",
                  op, a, b, k, got, exp_lat);
      end
      n_cmp++;
      if (res_data !== exp_d || res_flag !== exp_f) begin
         n_err++;
         $display("FAIL result op=%0d a=%0d b=%0d: got data=%0d flag=%b want data=%0d flag=%b",
                  op, a, b, res_data, res_flag, exp_d, exp_f);
      end
`ifdef ALU3_CMD_SEQ_ZFLAG_EN
      n_cmp++;
      if (res_zero !== (exp_d == '0)) begin
         n_err++;
         $display("FAIL res_zero op=%0d a=%0d b=%0d: got %b want %b",
                  op, a, b, res_zero, (exp_d == '0));
      end
`endif

      d0 = res_data;
      f0 = res_flag;
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1;
         cmd_op    = 2'($urandom);
         cmd_a     = DW'($urandom);
         cmd_b     = DW'($urandom);
         @(negedge clk);
         n_cmp++;
         if (res_valid !== 1'b1 || res_data !== d0 || res_flag !== f0 || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold cycle %0d: got valid=%b data=%0d flag=%b ready=%b want 1/%0d/%b/0",
                     i, res_valid, res_data, res_flag, cmd_ready, d0, f0);
         end
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL after_handshake: got valid=%b ready=%b want 0/1", res_valid, cmd_ready);
      end
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if (res_valid !== 1'b0 || res_data !== '0 || res_flag !== 1'b0 || cmd_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got valid=%b data=%0d flag=%b ready=%b want 0/0/0/0",
                  res_valid, res_data, res_flag, cmd_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: got ready=%b valid=%b want 1/0", cmd_ready, res_valid);
      end
   endtask

   task automatic test_directed();
      do_cmd(2'd0, 3'd5, 3'd6, 0);   // 3, carry
      do_cmd(2'd1, 3'd2, 3'd5, 0);   // 5, borrow
      do_cmd(2'd1, 3'd5, 3'd2, 0);   // 3, no borrow
      do_cmd(2'd2, 3'd4, 3'd3, 0);   // 0 (zero flag case)
      do_cmd(2'd3, 3'd6, 3'd2, 0);   // 1, flag 1, latency 3
      do_cmd(2'd3, 3'd7, 3'd5, 0);   // 0
      do_cmd(2'd3, 3'd5, 3'd0, 0);   // passthrough, latency 1
      do_cmd(2'd3, 3'd7, 3'd3, 0);   // shift by exactly DW
      do_cmd(2'd3, 3'd5, 3'd1, 0);
   endtask

   task automatic test_hold();
      do_cmd(2'd0, 3'd5, 3'd6, 4);
      do_cmd(2'd3, 3'd6, 3'd2, 4);
   endtask

   task automatic test_reset_mid_exec();
      logic saw;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rst_exec_ready: got %b want 1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_op    = 2'd3;
      cmd_a     = 3'd7;
      cmd_b     = 3'd6;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (res_valid !== 1'b0 || res_data !== '0 || res_flag !== 1'b0 || cmd_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rst_exec_zero: got valid=%b data=%0d flag=%b ready=%b want 0/0/0/0",
                  res_valid, res_data, res_flag, cmd_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rst_exec_ready_after: got %b want 1", cmd_ready);
      end
      saw = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (res_valid !== 1'b0) saw = 1'b1;
      end
      n_cmp++;
      if (saw !== 1'b0) begin
         n_err++;
         $display("FAIL rst_exec_no_result: got res_valid seen=%b want 0", saw);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         do_cmd(2'($urandom), DW'($urandom), DW'($urandom), int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) begin
         do_cmd(2'(i % 4), DW'($urandom), DW'($urandom_range(0, 3)), 0);
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_a     = '0;
      cmd_b     = '0;
      res_ready = 1'b0;

      test_reset();
      test_directed();
      test_hold();
      test_reset_mid_exec();
      test_random();
      test_back_to_back();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_alu3_cmd_seq
